// File: rtl/gyro_pkg.sv
// Shared types and helpers for the gyro-to-tilt sequencer.
//   SAMPLE_W     : width of one raw/corrected angular-velocity sample
//   rate_t       : signed sample type
//   ctrl_state_t : sequencer states
//   sat16        : clamp a 17-bit signed difference into rate_t
package gyro_pkg;

   localparam int unsigned SAMPLE_W = 16;

   typedef logic signed [SAMPLE_W-1:0] rate_t;

   typedef enum logic [2:0] {
      CAL_TICK,
      CAL_REQ,
      CAL_FIN,
      RUN_TICK,
      RUN_REQ,
      RUN_OUT
   } ctrl_state_t;

   // The two top bits differ exactly when the value does not fit in 16 bits.
   function automatic rate_t sat16(input logic signed [SAMPLE_W:0] v);
      if (v[SAMPLE_W] != v[SAMPLE_W-1]) begin
         return v[SAMPLE_W] ? 16'sh8000 : 16'sh7fff;
      end
      return rate_t'(v[SAMPLE_W-1:0]);
   endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running rate divider: one-cycle TICK every CLK_HZ/SAMPLE_HZ cycles.
//   CLK   : system clock, rising edge
//   RST_N : synchronous active-low reset (counter restarts at 0)
//   TICK  : high while the counter sits at TICK_DIV-1
module sample_tick_gen #(
   parameter int unsigned CLK_HZ    = 50_000_000,
   parameter int unsigned SAMPLE_HZ = 100
) (
   input  logic CLK,
   input  logic RST_N,
   output logic TICK
);

   localparam int unsigned TICK_DIV = CLK_HZ / SAMPLE_HZ;
   localparam int unsigned CntW     = $clog2(TICK_DIV);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign TICK = (cnt_q == CntW'(TICK_DIV - 1));

   always_comb begin
      cnt_d = TICK ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/gyro_tilt_ctrl.sv
// Sequencer between the gyro read FSM and the tilt integrator. Requests one
// sample per tick, averages 2^CAL_LOG2 samples into a per-axis bias after reset
// or ZERO, then forwards bias-corrected, saturated rates with an integrate strobe.
//   CLK, RST_N             : clock, synchronous active-low reset
//   ZERO                   : restart calibration (highest priority)
//   SMP_REQ / SMP_ACK      : sample handshake; SMP_D* valid with SMP_ACK
//   DX, DY, DZ             : corrected rates, held between updates
//   TILT_EN / TILT_RST     : one-cycle integrate / integrator-clear strobes
//   CAL_BUSY               : calibration in progress
//   ERR                    : sticky handshake timeout
module gyro_tilt_ctrl
   import gyro_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 50_000_000,
   parameter int unsigned SAMPLE_HZ = 100,
   parameter int unsigned CAL_LOG2  = 4,
   parameter int unsigned TIMEOUT   = 1000
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic                       ZERO,
   output logic                       SMP_REQ,
   input  logic                       SMP_ACK,
   input  logic signed [SAMPLE_W-1:0] SMP_DX,
   input  logic signed [SAMPLE_W-1:0] SMP_DY,
   input  logic signed [SAMPLE_W-1:0] SMP_DZ,
   output logic signed [SAMPLE_W-1:0] DX,
   output logic signed [SAMPLE_W-1:0] DY,
   output logic signed [SAMPLE_W-1:0] DZ,
   output logic                       TILT_EN,
   output logic                       TILT_RST,
   output logic                       CAL_BUSY,
   output logic                       ERR
);

   localparam int unsigned AccW  = SAMPLE_W + CAL_LOG2;
   localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

   ctrl_state_t               state_q, state_d;
   logic [WaitW-1:0]          wait_q, wait_d;
   logic [CAL_LOG2-1:0]       cnt_q, cnt_d;
   logic signed [AccW-1:0]    acc_q [3];
   logic signed [AccW-1:0]    acc_d [3];
   rate_t                     bias_q [3];
   rate_t                     bias_d [3];
   rate_t                     out_q [3];
   rate_t                     out_d [3];
   rate_t                     smp [3];
   logic                      req_q, req_d;
   logic                      err_q, err_d;
   logic                      tick;
   logic                      timed_out;

   sample_tick_gen #(
      .CLK_HZ    (CLK_HZ),
      .SAMPLE_HZ (SAMPLE_HZ)
   ) u_tick (
      .CLK   (CLK),
      .RST_N (RST_N),
      .TICK  (tick)
   );

   assign smp[0] = SMP_DX;
   assign smp[1] = SMP_DY;
   assign smp[2] = SMP_DZ;

   assign timed_out = (wait_q == WaitW'(TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      wait_d  = '0;       // only REQ states count; any other state rearms it
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      bias_d  = bias_q;
      out_d   = out_q;
      err_d   = err_q;

      if (ZERO) begin
         state_d = CAL_TICK;
         cnt_d   = '0;
         for (int a = 0; a < 3; a++) acc_d[a] = '0;
      end else begin
         unique case (state_q)
            CAL_TICK: if (tick) state_d = CAL_REQ;
            CAL_REQ: begin
               if (SMP_ACK) begin
                  for (int a = 0; a < 3; a++) begin
                     acc_d[a] = acc_q[a] + $signed({{CAL_LOG2{smp[a][SAMPLE_W-1]}}, smp[a]});
                  end
                  cnt_d   = cnt_q + 1'b1;
                  state_d = (&cnt_q) ? CAL_FIN : CAL_TICK;
               end else if (timed_out) begin
                  err_d   = 1'b1;
                  state_d = CAL_TICK;
               end else begin
                  wait_d = wait_q + 1'b1;
               end
            end
            CAL_FIN: begin
               for (int a = 0; a < 3; a++) begin
                  bias_d[a] = rate_t'(acc_q[a] >>> CAL_LOG2);
                  acc_d[a]  = '0;
               end
               cnt_d   = '0;
               state_d = RUN_TICK;
            end
            RUN_TICK: if (tick) state_d = RUN_REQ;
            RUN_REQ: begin
               if (SMP_ACK) begin
                  for (int a = 0; a < 3; a++) begin
                     out_d[a] = sat16($signed({smp[a][SAMPLE_W-1], smp[a]})
                                      - $signed({bias_q[a][SAMPLE_W-1], bias_q[a]}));
                  end
                  state_d = RUN_OUT;
               end else if (timed_out) begin
                  err_d   = 1'b1;
                  state_d = RUN_TICK;
               end else begin
                  wait_d = wait_q + 1'b1;
               end
            end
            RUN_OUT: state_d = RUN_TICK;
            default: state_d = CAL_TICK;
         endcase
      end

      req_d = (state_d == CAL_REQ) || (state_d == RUN_REQ);
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= CAL_TICK;
         wait_q  <= '0;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         err_q   <= 1'b0;
         for (int a = 0; a < 3; a++) begin
            acc_q[a]  <= '0;
            bias_q[a] <= '0;
            out_q[a]  <= '0;
         end
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         err_q   <= err_d;
         acc_q   <= acc_d;
         bias_q  <= bias_d;
         out_q   <= out_d;
      end
   end

   assign SMP_REQ  = req_q;
   assign ERR      = err_q;
   assign DX       = out_q[0];
   assign DY       = out_q[1];
   assign DZ       = out_q[2];
   assign TILT_EN  = (state_q == RUN_OUT);
   assign TILT_RST = (state_q == CAL_FIN);
   assign CAL_BUSY = (state_q == CAL_TICK) || (state_q == CAL_REQ) || (state_q == CAL_FIN);

endmodule
